// File: rtl/comparison_scheduler_pkg.sv
// Shared definitions for the comparison scheduler:
//   - opcode constants for the six signed relations (6 and 7 are reserved)
//   - the scheduler FSM state type
//   - cmp_signed(): the single signed comparison evaluated by the shared datapath
// Operands are sign-extended to CMP_W before comparison, so any operand width
// up to CMP_W bits shares this one function.
package comparison_scheduler_pkg;

  localparam int CMP_W = 64;

  localparam logic [2:0] OP_EQ = 3'd0;
  localparam logic [2:0] OP_NE = 3'd1;
  localparam logic [2:0] OP_LT = 3'd2;
  localparam logic [2:0] OP_LE = 3'd3;
  localparam logic [2:0] OP_GT = 3'd4;
  localparam logic [2:0] OP_GE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_COMPUTE,
    ST_RESPOND
  } state_e;

  function automatic logic cmp_signed(input logic signed [CMP_W-1:0] a,
                                      input logic signed [CMP_W-1:0] b,
                                      input logic [2:0]               op);
    logic r;
    case (op)
      OP_EQ:   r = (a == b);
      OP_NE:   r = (a != b);
      OP_LT:   r = (a <  b);
      OP_LE:   r = (a <= b);
      OP_GT:   r = (a >  b);
      OP_GE:   r = (a >= b);
      default: r = 1'b0;  // reserved opcodes are always false
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comparison_scheduler_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   req   in  N        request vector
//   ptr   in  IDX_W    priority pointer; search starts here and wraps N-1 -> 0
//   grant out N        one-hot winner (zero when no request)
//   idx   out IDX_W    encoded winner index (zero when no request)
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/comparison_scheduler.sv
// comparison_scheduler: one signed comparator shared round-robin among
// `requesters` stb/ack stream requesters, one comparison in flight at a time.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in1, in2      packed operands, slice i (bits wide) belongs to requester i
//   op            packed 3-bit opcodes
//   in_stb/in_ack request handshake, in_ack one-hot or zero
//   out1          packed results, only the granted slice is non-zero
//   out1_stb/ack  result handshake, out1_stb one-hot or zero
//   busy          high whenever the FSM is not idle
// All outputs decode from registered state, so no input reaches an output
// combinationally.
module comparison_scheduler
  import comparison_scheduler_pkg::*;
#(
  parameter int bits       = 16,
  parameter int requesters = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [requesters*bits-1:0]   in1,
  input  logic [requesters*bits-1:0]   in2,
  input  logic [requesters*3-1:0]      op,
  input  logic [requesters-1:0]        in_stb,
  output logic [requesters-1:0]        in_ack,
  output logic [requesters*bits-1:0]   out1,
  output logic [requesters-1:0]        out1_stb,
  input  logic [requesters-1:0]        out1_ack,
  output logic                         busy
);

  localparam int GW = (requesters > 1) ? $clog2(requesters) : 1;

  state_e                   state_q, state_d;
  logic [GW-1:0]            g_q, g_d;
  logic [GW-1:0]            p_q, p_d;
  logic signed [bits-1:0]   a_q, a_d;
  logic signed [bits-1:0]   b_q, b_d;
  logic [2:0]               op_q, op_d;
  logic                     res_q, res_d;

  logic [requesters-1:0]    pick_onehot;
  logic [GW-1:0]            pick_idx;
  logic                     pick_any;

  rr_picker #(
    .N     (requesters),
    .IDX_W (GW)
  ) u_rr_picker (
    .req   (in_stb),
    .ptr   (p_q),
    .grant (pick_onehot),
    .idx   (pick_idx)
  );

  assign pick_any = |pick_onehot;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          g_d     = pick_idx;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        // A requester that withdraws its strobe while acked forfeits the
        // grant; the pointer stays put so it keeps its priority.
        if (in_stb[g_q]) begin
          a_d     = $signed(in1[g_q*bits +: bits]);
          b_d     = $signed(in2[g_q*bits +: bits]);
          op_d    = op[g_q*3 +: 3];
          state_d = ST_COMPUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        res_d   = cmp_signed(CMP_W'(a_q), CMP_W'(b_q), op_q);
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (out1_ack[g_q]) begin
          p_d     = (g_q == GW'(requesters - 1)) ? '0 : g_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    in_ack   = '0;
    out1_stb = '0;
    out1     = '0;
    busy     = (state_q != ST_IDLE);
    if (state_q == ST_ACCEPT) begin
      in_ack[g_q] = 1'b1;
    end
    if (state_q == ST_RESPOND) begin
      out1_stb[g_q]            = 1'b1;
      out1[g_q*bits +: bits]   = {{(bits-1){1'b0}}, res_q};
    end
  end

endmodule

// File: doc/comparison_scheduler.md
# comparison_scheduler

Shares one signed comparison datapath among N stream requesters using the toolbox stb/ack handshake. Each requester presents two operands and an opcode. The block arbitrates round-robin, evaluates one comparison at a time, and returns a bits-wide result stream to the winning requester. It replaces per-site equal/not_equal/less_than/greater_than instances where comparison throughput is low.

## Interface
Parameters:
- bits, 16, operand and result width
- requesters, 4, number of requester ports (2..8)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- in1  in  requesters*bits  packed first operands; slice i belongs to requester i
- in2  in  requesters*bits  packed second operands
- op  in  requesters*3  packed opcodes
- in_stb  in  requesters  request valid, one bit per requester
- in_ack  out  requesters  request accepted, one-hot or zero
- out1  out  requesters*bits  packed results
- out1_stb  out  requesters  result valid, one-hot or zero
- out1_ack  in  requesters  result consumed
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes, all signed two's complement, evaluated as in1 OP in2:
  - 0 EQ
  - 1 NE
  - 2 LT
  - 3 LE
  - 4 GT
  - 5 GE
  - 6 and 7 are reserved and always give false.
- Result is 1 (zero-extended to bits) for true and 0 for false.
- A transfer occurs on a rising edge where stb and ack are both high.
- FSM states: IDLE, ACCEPT, COMPUTE, RESPOND.
- IDLE: if any in_stb is high, register the grant g and go to ACCEPT. Otherwise stay in IDLE.
- Grant selection: the first requester with in_stb high, searching upward from the priority pointer p and wrapping from requesters-1 to 0.
- ACCEPT: in_ack[g]=1.
  - If in_stb[g] is high, latch in1/in2/op slice g and go to COMPUTE.
  - If in_stb[g] has dropped (protocol violation), go to IDLE with no transfer and leave p unchanged.
- COMPUTE: register the comparison result and go to RESPOND.
- RESPOND: drive out1_stb[g]=1 and out1 slice g = result. Hold both until out1_ack[g]. On the transfer, set p=(g+1) mod requesters and go to IDLE.
- Non-granted out1 slices read 0. out1_ack bits of non-granted requesters are ignored.
- Only one comparison is in flight at a time; no other request is acknowledged until the result handshake completes.

## Timing
- Reset values: state=IDLE, p=0, g=0, in_ack=0, out1_stb=0, out1=0, busy=0, latched operands=0.
- in_ack and out1_stb are decoded from registered state and g only. There is no combinational path from any input to any output.
- Latency, with stb seen at edge 0: in_ack high in cycle 1, operands latched at edge 1, result registered at edge 2, out1_stb high from cycle 3.
- Minimum issue interval is 4 cycles per request when out1_ack is already high.
- Back-to-back: after the RESPOND transfer the block spends one cycle in IDLE before the next grant.
- Simultaneous requests: the pointer guarantees every continuously asserting requester is served within requesters grants.
- Reset asserted mid-operation clears all state immediately. Any pending result is discarded and no stb remains asserted.
- Pointer wrap: from g=requesters-1 the pointer returns to 0.

## Structure
- Shared package holds:
  - opcode constants OP_EQ..OP_GE
  - state enum
  - function for the signed compare of two bits-wide values
- One sub-module, rr_picker: combinational round-robin one-hot select from (req vector, pointer), plus the encoded index.
- The top holds the FSM, the operand/opcode latches, the result register and the slice muxing.
- Expected size is about 200 lines in total.

## Test plan
- Single request: requester 0, in1=-1, in2=2, op=LT, out1_ack tied high -> in_ack[0] in cycle 1, out1 slice 0 =1 with out1_stb[0] in cycle 3, busy high cycles 1–3.
- Opcode sweep on requester 2: in1=10, in2=0 -> EQ 0, NE 1, LT 0, LE 0, GT 1, GE 1, op 6 gives 0, op 7 gives 0. Also in1=0, in2=0 with GE -> 1.
- All four requesters asserting continuously from reset -> grants in order 0,1,2,3,0. Each result reaches only its own out1 slice; the other slices stay 0.
- Backpressure: out1_ack[1] held low for 10 cycles -> out1_stb[1] and out1 stay stable, no in_ack to others; release -> handshake completes, next grant is requester 2.
- in_stb[3] dropped during ACCEPT -> no operand latch, returns to IDLE, pointer unchanged, no out1_stb.
- rst pulsed during RESPOND -> all outputs return to reset values asynchronously; after release, the first grant goes to the lowest requesting index from p=0.
